// File: rtl/uartprobe_cmd_seq.sv
// Word-level command sequencer: expands one 32-bit request into probe byte commands and folds the replies into one response.
// Optional feature: define UARTPROBE_SEQ_ADDR_CACHE_EN to skip resending an AXI address that matches the last one sent.
module uartprobe_cmd_seq #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int POLL_MAX       = 16
) (
    input  logic        clk,
    input  logic        m_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        pr_valid,
    output logic [7:0]  pr_data,
    input  logic        pr_ready,
    input  logic        pt_valid,
    input  logic [7:0]  pt_data,
    output logic        pt_ready
);

    localparam logic [2:0] OP_GPO_WR = 3'd0;
    localparam logic [2:0] OP_GPO_RD = 3'd1;
    localparam logic [2:0] OP_GPI_RD = 3'd2;
    localparam logic [2:0] OP_AXI_WR = 3'd3;
    localparam logic [2:0] OP_AXI_RD = 3'd4;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    // Step indices: 0-7 address/data pairs, 8-9 AXI data/go pair, 10 ctrl poll, 11 AXI read data.
    localparam logic [3:0] STEP_AXI_CMD  = 4'd8;
    localparam logic [3:0] STEP_POLL     = 4'd10;
    localparam logic [3:0] STEP_AXI_DATA = 4'd11;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t         state;
    logic [2:0]     op_q;
    logic [31:0]    addr_q;
    logic [31:0]    data_q;
    logic [3:0]     step;
    logic [TW-1:0]  tcnt;
    logic [PW-1:0]  pcnt;
    logic [31:0]    acc;
    logic           axi_err;
    logic           cache_hit;
    logic [3:0]     start_step;
    logic           poll_done;

    function automatic logic is_axi(input logic [2:0] op);
        return (op == OP_AXI_WR) || (op == OP_AXI_RD);
    endfunction

    function automatic logic [7:0] step_byte(input logic [2:0] op, input logic [3:0] s,
                                             input logic [31:0] a, input logic [31:0] d);
        logic [7:0] b;
        b = 8'h00;
        case (op)
            OP_GPO_WR: b = s[0] ? d[{s[2:1], 3'b000} +: 8] : 8'd10 + {6'd0, s[2:1]};
            OP_GPO_RD: b = 8'd6 + {6'd0, s[1:0]};
            OP_GPI_RD: b = 8'd2 + {6'd0, s[1:0]};
            OP_AXI_WR, OP_AXI_RD: begin
                if (s < STEP_AXI_CMD) begin
                    b = s[0] ? a[{s[2:1], 3'b000} +: 8] : 8'd18 + {6'd0, s[2:1]};
                end else begin
                    case (s)
                        4'd8:    b = (op == OP_AXI_WR) ? 8'd23 : 8'd25;
                        4'd9:    b = (op == OP_AXI_WR) ? d[7:0] : 8'h01;
                        4'd10:   b = 8'd24;
                        default: b = 8'd22;
                    endcase
                end
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic needs_reply(input logic [2:0] op, input logic [3:0] s);
        return (op == OP_GPO_RD) || (op == OP_GPI_RD) || (is_axi(op) && s >= STEP_POLL);
    endfunction

    assign start_step = (is_axi(req_op) && cache_hit) ? STEP_AXI_CMD : 4'd0;
    assign poll_done  = (op_q == OP_AXI_WR) ? pt_data[2] : pt_data[3];

`ifdef UARTPROBE_SEQ_ADDR_CACHE_EN
    logic [31:0] last_addr;
    logic        cache_valid;
    logic        addr_sent;
    logic        seq_abort;

    assign cache_hit = cache_valid && (req_addr == last_addr);
    assign addr_sent = (state == SEND) && pr_ready && is_axi(op_q) && (step == 4'd7);
    // Any timeout abort leaves the probe's address register in doubt.
    assign seq_abort = (state == WAIT) &&
                       ((!pt_valid && tcnt == TW'(TIMEOUT_CYCLES - 1)) ||
                        (pt_valid && is_axi(op_q) && step == STEP_POLL && !poll_done &&
                         pcnt == PW'(POLL_MAX - 1)));

    always_ff @(posedge clk) begin
        if (m_reset) begin
            cache_valid <= 1'b0;
            last_addr   <= 32'h0;
        end else if (seq_abort) begin
            cache_valid <= 1'b0;
        end else if (addr_sent) begin
            cache_valid <= 1'b1;
            last_addr   <= addr_q;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (m_reset) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
            pr_valid  <= 1'b0;
            pr_data   <= 8'h00;
            pt_ready  <= 1'b0;
            op_q      <= 3'd0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            step      <= 4'd0;
            tcnt      <= '0;
            pcnt      <= '0;
            acc       <= 32'h0;
            axi_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        data_q    <= req_data;
                        acc       <= 32'h0;
                        axi_err   <= 1'b0;
                        pcnt      <= '0;
                        tcnt      <= '0;
                        if (req_op > OP_AXI_RD) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 32'h0;
                        end else begin
                            state    <= SEND;
                            step     <= start_step;
                            pr_valid <= 1'b1;
                            pr_data  <= step_byte(req_op, start_step, req_addr, req_data);
                        end
                    end
                end
                SEND: begin
                    if (pr_ready) begin
                        if (needs_reply(op_q, step)) begin
                            state    <= WAIT;
                            pr_valid <= 1'b0;
                            pt_ready <= 1'b1;
                            tcnt     <= '0;
                        end else if (op_q == OP_GPO_WR && step == 4'd7) begin
                            state     <= RESP;
                            pr_valid  <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= acc;
                        end else begin
                            step    <= step + 4'd1;
                            pr_data <= step_byte(op_q, step + 4'd1, addr_q, data_q);
                        end
                    end
                end
                WAIT: begin
                    if (pt_valid) begin
                        pt_ready <= 1'b0;
                        if (!is_axi(op_q)) begin
                            acc <= {acc[23:0], pt_data};
                            if (step == 4'd3) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                rsp_data  <= {acc[23:0], pt_data};
                            end else begin
                                state    <= SEND;
                                step     <= step + 4'd1;
                                pr_valid <= 1'b1;
                                pr_data  <= step_byte(op_q, step + 4'd1, addr_q, data_q);
                            end
                        end else if (step == STEP_POLL) begin
                            if (poll_done && op_q == OP_AXI_WR) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= |pt_data[5:4];
                                rsp_data  <= 32'h0;
                            end else if (poll_done) begin
                                axi_err  <= |pt_data[7:6];
                                state    <= SEND;
                                step     <= STEP_AXI_DATA;
                                pr_valid <= 1'b1;
                                pr_data  <= step_byte(op_q, STEP_AXI_DATA, addr_q, data_q);
                            end else if (pcnt == PW'(POLL_MAX - 1)) begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= 32'h0;
                            end else begin
                                // Still busy: resend the poll command.
                                pcnt     <= pcnt + PW'(1);
                                state    <= SEND;
                                pr_valid <= 1'b1;
                                pr_data  <= step_byte(op_q, STEP_POLL, addr_q, data_q);
                            end
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= axi_err;
                            rsp_data  <= {24'h0, pt_data};
                        end
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= RESP;
                        pt_ready  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= 32'h0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uartprobe_cmd_seq.sv
// Bench for uartprobe_cmd_seq: directed and random requests against a byte-stream reference model with a replying probe.
module tb_uartprobe_cmd_seq;

    localparam int TMO  = 8;
    localparam int PMAX = 4;

    logic        clk = 1'b0;
    logic        m_reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        pr_valid;
    logic [7:0]  pr_data;
    logic        pr_ready = 1'b0;
    logic        pt_valid = 1'b0;
    logic [7:0]  pt_data = 8'h00;
    logic        pt_ready;

    always #5 clk = ~clk;

    uartprobe_cmd_seq #(.TIMEOUT_CYCLES(TMO), .POLL_MAX(PMAX)) dut (
        .clk(clk), .m_reset(m_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .pr_valid(pr_valid), .pr_data(pr_data), .pr_ready(pr_ready),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  reply_q[$];
    logic [31:0] exp_data;
    logic        exp_err;
    bit          chk_data;
    bit          m_cache_valid = 1'b0;
    logic [31:0] m_last_addr = 32'h0;

    logic [31:0] got_rsp_data;
    logic        got_rsp_err;
    int          lat;
    int          pt_cycles;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: the byte stream and response the probe protocol calls for.
    // For GPO_RD/GPI_RD the probe's reply word is taken from d (MSB byte replied first).
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int n_busy, input logic [7:0] busy_ctrl, input logic [7:0] done_ctrl,
                         input logic [7:0] rd_byte);
        bit         skip;
        bit         wr;
        int         db;
        logic [7:0] c;
        exp_q.delete();
        reply_q.delete();
        exp_data = 32'h0;
        exp_err  = 1'b0;
        chk_data = 1'b1;
        case (op)
            3'd0: begin
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back(8'(10 + k));
                    exp_q.push_back(d[8*k +: 8]);
                end
                chk_data = 1'b0;
            end
            3'd1, 3'd2: begin
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back(8'((op == 3'd1 ? 6 : 2) + k));
                    reply_q.push_back(d[8*(3-k) +: 8]);
                end
                exp_data = d;
            end
            3'd3, 3'd4: begin
                wr   = (op == 3'd3);
                db   = wr ? 2 : 3;
                skip = 1'b0;
`ifdef UARTPROBE_SEQ_ADDR_CACHE_EN
                skip = m_cache_valid && (a == m_last_addr);
`endif
                if (!skip) begin
                    for (int k = 0; k < 4; k++) begin
                        exp_q.push_back(8'(18 + k));
                        exp_q.push_back(a[8*k +: 8]);
                    end
                    m_cache_valid = 1'b1;
                    m_last_addr   = a;
                end
                exp_q.push_back(wr ? 8'd23 : 8'd25);
                exp_q.push_back(wr ? d[7:0] : 8'h01);
                c = busy_ctrl;
                c[db] = 1'b0;
                if (n_busy >= PMAX) begin
                    for (int k = 0; k < PMAX; k++) begin
                        exp_q.push_back(8'd24);
                        reply_q.push_back(c);
                    end
                    exp_err = 1'b1;
                    m_cache_valid = 1'b0;
                end else begin
                    for (int k = 0; k < n_busy; k++) begin
                        exp_q.push_back(8'd24);
                        reply_q.push_back(c);
                    end
                    c = done_ctrl;
                    c[db] = 1'b1;
                    exp_q.push_back(8'd24);
                    reply_q.push_back(c);
                    exp_err = wr ? (c[5:4] != 2'b00) : (c[7:6] != 2'b00);
                    if (wr) begin
                        chk_data = 1'b0;
                    end else begin
                        exp_q.push_back(8'd22);
                        reply_q.push_back(rd_byte);
                        exp_data = {24'h0, rd_byte};
                    end
                end
            end
            default: exp_err = 1'b1;
        endcase
    endtask

    // Drives one request and plays the probe until the response is consumed.
    task automatic run_txn(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, input bit fast);
        int  guard;
        int  k;
        int  idle;
        bit  seen;
        bit  done;
        got_q.delete();
        lat = 0;
        pt_cycles = 0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_data  = $urandom;
        k = 1; idle = 0; seen = 1'b0; done = 1'b0;
        while (!done && k < 3000) begin
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat = k;
                    got_rsp_data = rsp_data;
                    got_rsp_err  = rsp_err;
                end
                rsp_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
                done = rsp_ready;
            end
            pr_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (pr_valid && pr_ready) got_q.push_back(pr_data);
            if (reply_q.size() > 0 && (fast || idle >= 3 || $urandom_range(0, 1) == 1)) begin
                pt_valid = 1'b1;
                pt_data  = reply_q[0];
                idle = 0;
            end else begin
                pt_valid = 1'b0;
                pt_data  = 8'($urandom);
                if (reply_q.size() > 0) idle++;
            end
            if (pt_valid && pt_ready) void'(reply_q.pop_front());
            if (pt_ready) pt_cycles++;
            @(negedge clk);
            k++;
        end
        rsp_ready = 1'b0;
        pr_ready  = 1'b0;
        pt_valid  = 1'b0;
        chk({name, "_completed"}, done, 1'b1);
        chk({name, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
        chk({name, "_replies_used"}, reply_q.size(), 0);
        chk({name, "_rsp_err"}, got_rsp_err, exp_err);
        if (chk_data) chk({name, "_rsp_data"}, got_rsp_data, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_seen;
        logic [2:0]  op;
        logic [31:0] a;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_pr_valid", pr_valid, 1'b0);
        chk("rst_pr_data", pr_data, 8'h00);
        chk("rst_pt_ready", pt_ready, 1'b0);
        m_reset = 1'b0;

        // GPO write with full-rate probe: 8 send cycles then the response
        model(3'd0, 32'h0, 32'hA1B2C3D4, 0, 8'h00, 8'h00, 8'h00);
        run_txn("gpo_wr", 3'd0, 32'h0, 32'hA1B2C3D4, 1'b1);
        chk("gpo_wr_latency", lat, 9);

        // GPI read assembled MSB first
        model(3'd2, 32'h0, 32'h12345678, 0, 8'h00, 8'h00, 8'h00);
        run_txn("gpi_rd", 3'd2, 32'h0, 32'h12345678, 1'b0);

        // GPO read
        model(3'd1, 32'h0, 32'hCAFE0123, 0, 8'h00, 8'h00, 8'h00);
        run_txn("gpo_rd", 3'd1, 32'h0, 32'hCAFE0123, 1'b0);

        // AXI read: one busy poll, then done, then data byte
        model(3'd4, 32'h40000010, 32'h0, 1, 8'h00, 8'h08, 8'h5A);
        run_txn("axi_rd", 3'd4, 32'h40000010, 32'h0, 1'b0);

        // AXI write with nonzero write response
        model(3'd3, 32'h20000004, 32'h00000077, 0, 8'h00, 8'h24, 8'h00);
        run_txn("axi_wr_err", 3'd3, 32'h20000004, 32'h00000077, 1'b0);

        // AXI write whose ctrl never reports done
        model(3'd3, 32'h30000000, 32'h00000011, PMAX, 8'h00, 8'h00, 8'h00);
        run_txn("axi_poll_max", 3'd3, 32'h30000000, 32'h00000011, 1'b0);

        // Probe silent: timeout after TMO waiting cycles
        model(3'd2, 32'h0, 32'h0, 0, 8'h00, 8'h00, 8'h00);
        reply_q.delete();
        exp_q.delete();
        exp_q.push_back(8'd2);
        exp_err = 1'b1;
        exp_data = 32'h0;
        m_cache_valid = 1'b0;
        run_txn("timeout", 3'd2, 32'h0, 32'h0, 1'b0);
        chk("timeout_wait_cycles", pt_cycles, TMO);

        // Two AXI reads to the same address
        model(3'd4, 32'h00000100, 32'h0, 0, 8'h00, 8'h08, 8'h3C);
        run_txn("axi_rd_a", 3'd4, 32'h00000100, 32'h0, 1'b0);
        model(3'd4, 32'h00000100, 32'h0, 2, 8'h00, 8'h48, 8'hC3);
        run_txn("axi_rd_b", 3'd4, 32'h00000100, 32'h0, 1'b0);

        // Illegal op answers at once
        model(3'd6, 32'h0, 32'h0, 0, 8'h00, 8'h00, 8'h00);
        run_txn("illegal_op", 3'd6, 32'h0, 32'h0, 1'b1);
        chk("illegal_latency", lat, 1);

        // Reset in the middle of a send
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_data = 32'h55667788;
        @(negedge clk);
        req_valid = 1'b0; pr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_send_pr_valid", pr_valid, 1'b1);
        m_reset = 1'b1;
        @(negedge clk);
        chk("abort_pr_valid", pr_valid, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        m_reset = 1'b0;
        pr_ready = 1'b0;
        m_cache_valid = 1'b0;
        n_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || pr_valid) n_seen++;
        end
        chk("abort_quiet", n_seen, 0);

        // Random mix, small address pool so repeats occur
        for (int t = 0; t < 40; t++) begin
            op = 3'($urandom_range(0, 7));
            if (op > 3'd4 && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 4));
            case ($urandom_range(0, 2))
                0: a = 32'h00000100;
                1: a = 32'h80001234;
                default: a = $urandom;
            endcase
            begin
                logic [31:0] d;
                d = $urandom;
                model(op, a, d, $urandom_range(0, PMAX), 8'($urandom), 8'($urandom), 8'($urandom));
                run_txn($sformatf("rnd%0d", t), op, a, d, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
